// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
//
// Shared definitions for the push-button conditioner slice:
//   - btn_state_e : hold/auto-repeat FSM state encoding
//   - default parameter values sized for a 12 MHz board clock
//   - maxInt()    : helper used to size the hold/repeat timer
// ---------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } btn_state_e;

    localparam int CLK_HZ              = 12_000_000;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEBOUNCE_DEFAULT    = 16;
    // First auto-repeat after half a second, then ten repeats per second.
    localparam int HOLD_DEFAULT        = CLK_HZ / 2;
    localparam int REPEAT_DEFAULT      = CLK_HZ / 10;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_sync.sv
// ---------------------------------------------------------------------------
// button_sync
//
// Plain multi-flop synchronizer bringing the raw, asynchronous button into
// the clk_i domain. Every stage clears to 0 on reset.
//
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (last flop of the chain)
// ---------------------------------------------------------------------------
module button_sync #(
    parameter int sync_stages_p = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [sync_stages_p-1:0] r_chain;

    // Shift the raw input one stage further into the clock domain every
    // cycle; only the final stage is considered safe to use downstream.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[sync_stages_p-2:0], d_i};
        end
    end

    assign q_o = r_chain[sync_stages_p-1];

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Turns one raw bouncing push-button into a clean debounced level plus
// single-cycle press / release / auto-repeat pulses suitable for driving the
// up/down counter directly. Synchronizer, debounce filter, edge detection
// and hold-to-repeat all live here.
//
// Optional feature macro: BUTTON_CONDITIONER_REPEAT_EN
//   defined   : after holding for hold_p cycles, repeat_o pulses every
//               repeat_p cycles until the button is released
//   undefined : no timer is built, the FSM parks in HOLD while the button
//               is down and repeat_o is tied low
//
// Ports:
//   clk_i      : clock
//   reset_n_i  : asynchronous active-low reset
//   button_i   : raw button, active-high, asynchronous, bouncing
//   level_o    : debounced button level
//   press_o    : one-cycle pulse in the first cycle level_o reads 1
//   release_o  : one-cycle pulse in the first cycle level_o reads 0
//   repeat_o   : one-cycle auto-repeat pulse while held
// ---------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int sync_stages_p = SYNC_STAGES_DEFAULT,
    parameter int debounce_p    = DEBOUNCE_DEFAULT,
    parameter int hold_p        = HOLD_DEFAULT,
    parameter int repeat_p      = REPEAT_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic button_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    if (sync_stages_p < 2 || debounce_p < 1 || hold_p < 2 || repeat_p < 1) begin : g_badParams
        $error("button_conditioner: parameter below its minimum");
    end

    localparam int DebWidth = (debounce_p > 1) ? $clog2(debounce_p) : 1;
    localparam logic [DebWidth-1:0] DebLast = DebWidth'(debounce_p - 1);

    logic                w_sync;
    logic [DebWidth-1:0] r_debCount;
    logic                r_level;
    logic                w_debDone;
    logic                w_rise;
    logic                w_fall;

    btn_state_e r_state;
    btn_state_e w_stateNext;

    logic w_pressNext;
    logic w_releaseNext;
    logic r_press;
    logic r_release;

    button_sync #(
        .sync_stages_p(sync_stages_p)
    ) u_sync (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .d_i      (button_i),
        .q_o      (w_sync)
    );

    // The debounced level flips on the debounce_p-th consecutive cycle in
    // which the synchronized input disagrees with it; these decodes flag
    // that cycle so the FSM and pulse logic move in lockstep with level_o.
    assign w_debDone = (w_sync != r_level) && (r_debCount == DebLast);
    assign w_rise    = w_debDone &&  w_sync;
    assign w_fall    = w_debDone && !w_sync;

    // Debounce filter: count consecutive disagreeing cycles, clear the
    // count on any agreeing cycle and whenever the level is updated.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_debCount <= '0;
            r_level    <= 1'b0;
        end else if (w_sync != r_level) begin
            if (w_debDone) begin
                r_level    <= w_sync;
                r_debCount <= '0;
            end else begin
                r_debCount <= r_debCount + 1'b1;
            end
        end else begin
            r_debCount <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

`ifdef BUTTON_CONDITIONER_REPEAT_EN

    localparam int TimerWidth = $clog2(maxInt(hold_p, repeat_p));
    localparam logic [TimerWidth-1:0] HoldLast   = TimerWidth'(hold_p - 1);
    localparam logic [TimerWidth-1:0] RepeatLast = TimerWidth'(repeat_p - 1);

    logic [TimerWidth-1:0] r_timer;
    logic [TimerWidth-1:0] w_timerNext;
    logic                  w_repeatNext;
    logic                  r_repeat;

    // The timer is cleared on every terminal count, so it never needs to
    // reach beyond max(hold_p, repeat_p)-1.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timerNext;
        end
    end

    // Next-state and timer decode. A debounced release wins over anything
    // the hold/repeat timer is doing in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        if (w_fall) begin
            w_stateNext = IDLE;
            w_timerNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_timerNext = '0;
                    if (w_rise) begin
                        w_stateNext = HOLD;
                    end
                end
                HOLD: begin
                    if (r_timer == HoldLast) begin
                        w_stateNext = REPEAT;
                        w_timerNext = '0;
                    end else begin
                        w_timerNext = r_timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (r_timer == RepeatLast) begin
                        w_timerNext = '0;
                    end else begin
                        w_timerNext = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_timerNext = '0;
                end
            endcase
        end
    end

    // Output decode: pulses are computed one cycle early so they land in
    // the output flops on the same edge as the matching level/state change.
    always_comb begin
        w_pressNext   = (r_state == IDLE) && w_rise;
        w_releaseNext = w_fall;
        w_repeatNext  = 1'b0;
        if (!w_fall) begin
            w_repeatNext = ((r_state == HOLD)   && (r_timer == HoldLast)) ||
                           ((r_state == REPEAT) && (r_timer == RepeatLast));
        end
    end

    // Auto-repeat output register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= w_repeatNext;
        end
    end

    assign repeat_o = r_repeat;

`else

    // Next-state decode without auto-repeat: HOLD simply marks "button is
    // down" until the debounced release sends the FSM back to IDLE.
    always_comb begin
        w_stateNext = r_state;
        if (w_fall) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_stateNext = HOLD;
                    end
                end
                HOLD: begin
                    w_stateNext = HOLD;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Output decode for press/release; no repeat source exists here.
    always_comb begin
        w_pressNext   = (r_state == IDLE) && w_rise;
        w_releaseNext = w_fall;
    end

    assign repeat_o = 1'b0;

`endif

    // Press/release output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_pressNext;
            r_release <= w_releaseNext;
        end
    end

    assign level_o   = r_level;
    assign press_o   = r_press;
    assign release_o = r_release;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner (sync 2, debounce 4, hold 10,
// repeat 3). Every cycle the DUT outputs are compared against a reference
// model built from the behavioural rules: the synchronized button is the raw
// sample sync_stages_p edges ago, the level flips when the last debounce_p
// synchronized samples all disagree with it, and repeats fall at
// hold_p + n*repeat_p edges after the press. Directed scenarios add explicit
// latency and count checks on top.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int SyncStages = 2;
    localparam int Debounce   = 4;
    localparam int Hold       = 10;
    localparam int Repeat     = 3;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b0;
    logic button_i  = 1'b0;
    logic level_o;
    logic press_o;
    logic release_o;
    logic repeat_o;

    int vectors     = 0;
    int miscompares = 0;

    logic sampQ[$];
    logic syncQ[$];
    logic mLevel;
    logic mPress;
    logic mRelease;
    logic mRepeat;
    int   edgeK;
    int   pressK;

    button_conditioner #(
        .sync_stages_p(SyncStages),
        .debounce_p   (Debounce),
        .hold_p       (Hold),
        .repeat_p     (Repeat)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .button_i (button_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .repeat_o (repeat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        sampQ.delete();
        syncQ.delete();
        mLevel   = 1'b0;
        mPress   = 1'b0;
        mRelease = 1'b0;
        mRepeat  = 1'b0;
        edgeK    = 0;
        pressK   = 0;
    endfunction

    function automatic void modelStep(input logic btn);
        logic seen;
        logic prevLevel;
        bit   allDiffer;
        int   d;
        edgeK++;
        sampQ.push_back(btn);
        seen = (sampQ.size() > SyncStages) ? sampQ[sampQ.size() - 1 - SyncStages] : 1'b0;
        syncQ.push_back(seen);
        if (sampQ.size() > 64) void'(sampQ.pop_front());
        if (syncQ.size() > 64) void'(syncQ.pop_front());
        allDiffer = (syncQ.size() >= Debounce);
        for (int i = 0; i < Debounce && i < syncQ.size(); i++) begin
            if (syncQ[syncQ.size() - 1 - i] == mLevel) allDiffer = 1'b0;
        end
        prevLevel = mLevel;
        if (allDiffer) mLevel = ~mLevel;
        mPress   = !prevLevel &&  mLevel;
        mRelease =  prevLevel && !mLevel;
        mRepeat  = 1'b0;
        if (mPress) pressK = edgeK;
        if (RepeatEn && prevLevel && mLevel) begin
            d = edgeK - pressK;
            if (d >= Hold && ((d - Hold) % Repeat) == 0) mRepeat = 1'b1;
        end
    endfunction

    // One clock: advance the model on the edge, check #1 later, then drive
    // the button value that the next edge will sample.
    task automatic applyStimulus(input logic nextBtn);
        @(posedge clk_i);
        if (!reset_n_i) modelReset();
        else            modelStep(button_i);
        #1;
        checkOutput("level",   level_o,   mLevel);
        checkOutput("press",   press_o,   mPress);
        checkOutput("release", release_o, mRelease);
        checkOutput("repeat",  repeat_o,  mRepeat);
        button_i = nextBtn;
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "Level"},   level_o,   1'b0);
        checkOutput({tag, "Press"},   press_o,   1'b0);
        checkOutput({tag, "Release"}, release_o, 1'b0);
        checkOutput({tag, "Repeat"},  repeat_o,  1'b0);
    endtask

    initial begin
        int pressAt;
        int releaseAt;
        int repeatAt;
        int repeats;
        int lateRepeats;
        int presses;
        int releases;
        int events;
        logic lvl;
        int len;

        modelReset();

        // Scenario 1: reset held while the button toggles.
        #1;
        checkAllLow("rstInit");
        for (int i = 0; i < 6; i++) applyStimulus((i % 2) == 0);
        applyStimulus(1'b0);
        reset_n_i = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0);

        // Scenario 2: clean press just after edge 0, held through edge 27.
        applyStimulus(1'b1);
        pressAt = -1;
        repeats = 0;
        for (int e = 1; e <= 27; e++) begin
            applyStimulus((e == 27) ? 1'b0 : 1'b1);
            if (press_o && pressAt < 0) pressAt = e;
            if (repeat_o) repeats++;
        end
        checkOutput("s2PressEdge", pressAt, 6);
        checkOutput("s2RepeatCount", repeats, RepeatEn ? 4 : 0);

        // Scenario 3: release just after edge 27.
        releaseAt   = -1;
        lateRepeats = 0;
        for (int e = 28; e <= 40; e++) begin
            applyStimulus(1'b0);
            if (release_o && releaseAt < 0) releaseAt = e;
            if (releaseAt >= 0 && repeat_o) lateRepeats++;
        end
        checkOutput("s3ReleaseEdge", releaseAt, 33);
        checkOutput("s3LateRepeats", lateRepeats, 0);

        // Scenario 4: bounce every 2 cycles, then settle high.
        pressAt  = -1;
        presses  = 0;
        releases = 0;
        for (int f = 0; f < 27; f++) begin
            applyStimulus((f < 12) ? ((f % 4) < 2) : 1'b1);
            if (press_o) begin
                presses++;
                if (pressAt < 0) pressAt = f;
            end
            if (release_o) releases++;
        end
        checkOutput("s4PressCount", presses, 1);
        checkOutput("s4PressEdge", pressAt, 18);
        checkOutput("s4Releases", releases, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0);

        // Scenario 5: 3-cycle glitch must be filtered out.
        events = 0;
        for (int f = 0; f < 15; f++) begin
            applyStimulus(f < 3);
            if (level_o || press_o || release_o) events++;
        end
        checkOutput("s5GlitchEvents", events, 0);

        // Scenario 6: reset at edge 20 of a held press, button still held.
        applyStimulus(1'b1);
        for (int e = 1; e <= 20; e++) applyStimulus(1'b1);
        #2;
        reset_n_i = 1'b0;
        #1;
        checkAllLow("s6Rst");
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        reset_n_i = 1'b1;
        pressAt  = -1;
        repeatAt = -1;
        for (int e = 1; e <= 30; e++) begin
            applyStimulus(1'b1);
            if (press_o && pressAt < 0) pressAt = e;
            if (repeat_o && repeatAt < 0) repeatAt = e;
        end
        checkOutput("s6PressEdge", pressAt, 6);
        checkOutput("s6FirstRepeat", repeatAt, RepeatEn ? 16 : -1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0);

        // Randomized segments with occasional asynchronous resets.
        for (int seg = 0; seg < 60; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                              : int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) applyStimulus(lvl);
            if ($urandom_range(0, 19) == 0) begin
                #2;
                reset_n_i = 1'b0;
                #1;
                checkAllLow("rndRst");
                applyStimulus(lvl);
                reset_n_i = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
